// File: rtl/fp_add_pipe.sv
// Four-stage pipelined floating-point adder/subtractor: RNE rounding, IEEE specials, subnormals flushed.
// Define FPADD_FLAGS_EN to add Flags = {invalid, overflow, underflow, inexact}, aligned with Result.
module fp_add_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [EXP_W+MAN_W:0]   OpA,
    input  logic [EXP_W+MAN_W:0]   OpB,
    input  logic                   Sub,
    input  logic                   InValid,
    output logic                   InReady,
    output logic [EXP_W+MAN_W:0]   Result,
`ifdef FPADD_FLAGS_EN
    output logic [3:0]             Flags,
`endif
    output logic                   OutValid,
    input  logic                   OutReady
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 4;
    localparam int XW = EXP_W + 2;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

    function automatic logic [XW-1:0] lzc(input logic [MW-1:0] v);
        logic [XW-1:0] n;
        n = XW'(MW);
        for (int i = 0; i < MW; i++)
            if (v[i]) n = XW'(MW - 1 - i);
        return n;
    endfunction

    logic stall;
    logic out_valid_q;
    logic [W-1:0] result_d, result_q;

    assign stall    = out_valid_q && !OutReady;
    assign InReady  = !stall;
    assign OutValid = out_valid_q;
    assign Result   = result_q;

    logic sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge_b, sticky;
    logic [EXP_W-1:0] ea, eb, diff;
    logic [MAN_W-1:0] ma, mb;
    logic [MW-1:0] small_m, shifted;
    logic s1_valid_q, s1_special_d, s1_special_q, s1_sign_d, s1_sign_q, s1_sub_d, s1_sub_q, s1_nan_d;
    logic [W-1:0] s1_spec_d, s1_spec_q;
    logic [EXP_W-1:0] s1_exp_d, s1_exp_q;
    logic [MW-1:0] s1_big_d, s1_big_q, s1_small_d, s1_small_q;

    always_comb begin
        sa = OpA[W-1];
        ea = OpA[W-2:MAN_W];
        ma = OpA[MAN_W-1:0];
        sb = OpB[W-1] ^ Sub;
        eb = OpB[W-2:MAN_W];
        mb = OpB[MAN_W-1:0];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == '1) && (ma == '0);
        b_inf  = (eb == '1) && (mb == '0);
        a_nan  = (ea == '1) && (ma != '0);
        b_nan  = (eb == '1) && (mb != '0);

        s1_nan_d     = a_nan || b_nan || (a_inf && b_inf && (sa != sb));
        s1_special_d = 1'b1;
        if (s1_nan_d)                s1_spec_d = QNAN;
        else if (a_inf)              s1_spec_d = {sa, ea, ma};
        else if (b_inf)              s1_spec_d = {sb, eb, mb};
        else if (a_zero && b_zero)   s1_spec_d = {sa && sb, {(W-1){1'b0}}};
        else if (a_zero)             s1_spec_d = {sb, eb, mb};
        else if (b_zero)             s1_spec_d = {sa, ea, ma};
        else begin
            s1_special_d = 1'b0;
            s1_spec_d    = '0;
        end

        // Larger magnitude goes first so the stage-2 difference is never negative.
        a_ge_b    = {ea, ma} >= {eb, mb};
        s1_sign_d = a_ge_b ? sa : sb;
        s1_sub_d  = (sa != sb);
        s1_exp_d  = a_ge_b ? ea : eb;
        diff      = a_ge_b ? ea - eb : eb - ea;
        s1_big_d  = {1'b1, a_ge_b ? ma : mb, 3'b000};
        small_m   = {1'b1, a_ge_b ? mb : ma, 3'b000};
        shifted   = small_m >> diff;
        sticky    = 1'b0;
        for (int i = 0; i < MW; i++)
            if (i < int'(diff)) sticky = sticky | small_m[i];
        if (int'(diff) >= MAN_W + 3) s1_small_d = {{(MW-1){1'b0}}, 1'b1};
        else                         s1_small_d = {shifted[MW-1:1], shifted[0] | sticky};
    end

    logic s2_valid_q, s2_special_q, s2_sign_q;
    logic [W-1:0] s2_spec_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic [MW:0] s2_sum_d, s2_sum_q;

    always_comb begin
        s2_sum_d = s1_sub_q ? ({1'b0, s1_big_q} - {1'b0, s1_small_q})
                            : ({1'b0, s1_big_q} + {1'b0, s1_small_q});
    end

    logic [XW-1:0] lz;
    logic signed [XW-1:0] e_ext, e_adj, s3_exp_d, s3_exp_q;
    logic [MW-1:0] s3_norm_d, s3_norm_q;
    logic s3_valid_q, s3_special_q, s3_sign_q, s3_zero_d, s3_zero_q;
    logic [W-1:0] s3_spec_q;

    always_comb begin
        s3_zero_d = (s2_sum_q == '0);
        lz        = lzc(s2_sum_q[MW-1:0]);
        e_ext     = signed'({2'b00, s2_exp_q});
        e_adj     = e_ext - signed'(lz);
        if (s2_sum_q[MW]) begin
            s3_norm_d = {s2_sum_q[MW:2], s2_sum_q[1] | s2_sum_q[0]};
            s3_exp_d  = e_ext + XW'(1);
        end else begin
            s3_norm_d = s2_sum_q[MW-1:0] << lz;
            s3_exp_d  = (e_adj < 0) ? '0 : e_adj;
        end
    end

    logic rnd_g, rnd_r, rnd_s, round_up, is_ovf, is_unf;
    logic [MAN_W+1:0] mr;
    logic signed [XW-1:0] exp_r;
    logic [MAN_W-1:0] man_out;

    always_comb begin
        {rnd_g, rnd_r, rnd_s} = s3_norm_q[2:0];
        round_up = rnd_g && (rnd_r || rnd_s || s3_norm_q[3]);
        mr       = {1'b0, s3_norm_q[MW-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
        exp_r    = s3_exp_q + signed'({{(XW-1){1'b0}}, mr[MAN_W+1]});
        man_out  = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
        is_ovf   = !s3_special_q && !s3_zero_q && (exp_r >= EXP_MAX);
        is_unf   = !s3_special_q && !s3_zero_q && !is_ovf && (exp_r <= 0);
        if (s3_special_q)  result_d = s3_spec_q;
        else if (s3_zero_q) result_d = '0;
        else if (is_ovf)    result_d = {s3_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (is_unf)    result_d = {s3_sign_q, {(W-1){1'b0}}};
        else                result_d = {s3_sign_q, exp_r[EXP_W-1:0], man_out};
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s3_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else if (!stall) begin
            s1_valid_q  <= InValid;
            s2_valid_q  <= s1_valid_q;
            s3_valid_q  <= s2_valid_q;
            out_valid_q <= s3_valid_q;
            result_q    <= result_d;
        end
    end

    // NOTE: datapath registers carry no reset; the stage valid bits alone give them meaning.
    always_ff @(posedge Clock) begin
        if (!stall) begin
            s1_special_q <= s1_special_d;
            s1_spec_q    <= s1_spec_d;
            s1_sign_q    <= s1_sign_d;
            s1_sub_q     <= s1_sub_d;
            s1_exp_q     <= s1_exp_d;
            s1_big_q     <= s1_big_d;
            s1_small_q   <= s1_small_d;
            s2_special_q <= s1_special_q;
            s2_spec_q    <= s1_spec_q;
            s2_sign_q    <= s1_sign_q;
            s2_exp_q     <= s1_exp_q;
            s2_sum_q     <= s2_sum_d;
            s3_special_q <= s2_special_q;
            s3_spec_q    <= s2_spec_q;
            s3_sign_q    <= s2_sign_q;
            s3_zero_q    <= s3_zero_d;
            s3_exp_q     <= s3_exp_d;
            s3_norm_q    <= s3_norm_d;
        end
    end

`ifdef FPADD_FLAGS_EN
    logic s1_inv_q, s2_inv_q, s3_inv_q;
    logic [3:0] flags_d, flags_q;

    always_comb begin
        flags_d    = {s3_special_q && s3_inv_q, is_ovf, is_unf, 1'b0};
        flags_d[0] = is_ovf || is_unf ||
                     (!s3_special_q && !s3_zero_q && (rnd_g || rnd_r || rnd_s));
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            flags_q <= '0;
        end else if (!stall) begin
            flags_q <= flags_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (!stall) begin
            s1_inv_q <= s1_nan_d;
            s2_inv_q <= s1_inv_q;
            s3_inv_q <= s2_inv_q;
        end
    end

    assign Flags = flags_q;
`endif

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed bench for fp_add_pipe (binary32): latency, rounding, specials, stall streaming, mid-flight reset.
module tb_fp_add_pipe;
    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] OpA, OpB;
    logic        Sub, InValid, InReady;
    logic [31:0] Result;
    logic        OutValid, OutReady;
`ifdef FPADD_FLAGS_EN
    logic [3:0]  Flags;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .OpA      (OpA),
        .OpB      (OpB),
        .Sub      (Sub),
        .InValid  (InValid),
        .InReady  (InReady),
        .Result   (Result),
`ifdef FPADD_FLAGS_EN
        .Flags    (Flags),
`endif
        .OutValid (OutValid),
        .OutReady (OutReady)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One isolated operation: accept, measure acceptance-to-OutValid latency, check result, drain.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [31:0] exp, input logic [3:0] ef);
        int lat;
        OpA = a;
        OpB = b;
        Sub = sub;
        InValid = 1'b1;
        check({tag, "/in_ready"}, 32'(InReady), 32'd1);
        tick;
        InValid = 1'b0;
        lat = 1;
        while (!OutValid && lat < 12) begin
            tick;
            lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'd4);
        check({tag, "/result"}, Result, exp);
`ifdef FPADD_FLAGS_EN
        check({tag, "/flags"}, 32'(Flags), 32'(ef));
`endif
        tick;
        check({tag, "/drained"}, 32'(OutValid), 32'd0);
    endtask

    logic [31:0] s_a   [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] s_exp [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                               32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

    initial begin
        int snd;
        int rcv;
        int cyc;
        logic seen;

        Reset    = 1'b1;
        InValid  = 1'b0;
        OutReady = 1'b1;
        OpA      = '0;
        OpB      = '0;
        Sub      = 1'b0;
        tick;
        tick;
        check("reset/out_valid", 32'(OutValid), 32'd0);
        check("reset/result", Result, 32'h0);
        Reset = 1'b0;
        check("reset/in_ready", 32'(InReady), 32'd1);

        run_op("add_1_2",     32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
        run_op("sub_1_1",     32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
        run_op("negzero",     32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
        run_op("tie_even",    32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
        run_op("round_up",    32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001);
        run_op("overflow",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
        run_op("inf_m_inf",   32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
        run_op("nan_in",      32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
        run_op("sub_3_1",     32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
        run_op("subnorm_ftz", 32'h3F800000, 32'h00400000, 1'b0, 32'h3F800000, 4'b0000);
        run_op("underflow",   32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);

        // Back-to-back stream of 8 ops, downstream stalls in cycles 5..7.
        snd = 0;
        rcv = 0;
        cyc = 0;
        Sub = 1'b0;
        OpB = 32'h3F800000;
        while (rcv < 8 && cyc < 60) begin
            OutReady = !(cyc >= 5 && cyc <= 7);
            InValid  = (snd < 8);
            OpA      = (snd < 8) ? s_a[snd] : 32'h0;
            #1;
            if (cyc <= 9)
                check($sformatf("stream/in_ready_c%0d", cyc), 32'(InReady),
                      32'((cyc < 5 || cyc > 7) ? 1 : 0));
            if (OutValid && !OutReady)
                check($sformatf("stream/hold_c%0d", cyc), Result, s_exp[rcv]);
            if (OutValid && OutReady) begin
                check($sformatf("stream/out%0d", rcv), Result, s_exp[rcv]);
                rcv++;
            end
            if (InValid && InReady) snd++;
            tick;
            cyc++;
        end
        InValid  = 1'b0;
        OutReady = 1'b1;
        check("stream/received", 32'(rcv), 32'd8);
        check("stream/sent", 32'(snd), 32'd8);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            seen = seen | OutValid;
            tick;
        end
        check("stream/no_extra", 32'(seen), 32'd0);

        // Reset with three operations in flight.
        OpA = 32'h3F800000;
        OpB = 32'h40000000;
        for (int k = 0; k < 3; k++) begin
            InValid = 1'b1;
            tick;
        end
        InValid = 1'b0;
        Reset   = 1'b1;
        tick;
        check("midrst/out_valid", 32'(OutValid), 32'd0);
        check("midrst/result", Result, 32'h0);
        Reset = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick;
            seen = seen | OutValid;
        end
        check("midrst/no_stale", 32'(seen), 32'd0);
        check("midrst/in_ready", 32'(InReady), 32'd1);
        run_op("after_rst", 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
